// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types, defaults and field-width helpers for the set-associative icache
package cpu_types_pkg;

    localparam int ICACHE_SETS_DEFAULT  = 8;
    localparam int ICACHE_WAYS_DEFAULT  = 2;
    localparam int ICACHE_WPB_DEFAULT   = 2;
    localparam int ICACHE_CNT_W_DEFAULT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_assoc_state_t;

    // Number of address bits a field of n entries occupies (0 when n == 1).
    function automatic int field_w(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Width of a select signal for n entries; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/caches_if.sv
// rtl/caches_if.sv - memory controller port used by the instruction cache
interface caches_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport icache (
        output iREN, iaddr,
        input  iwait, iload
    );
endinterface

// File: rtl/datapath_cache_if.sv
// rtl/datapath_cache_if.sv - datapath fetch port as seen by the instruction cache
interface datapath_cache_if;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic        ihit;
    logic [31:0] imemload;

    modport cache (
        input  halt, imemREN, imemaddr, dmemREN, dmemWEN,
        output ihit, imemload
    );
endinterface

// File: rtl/icache_assoc_way.sv
// rtl/icache_assoc_way.sv - one way of the icache: valid/tag/data storage and tag compare
module icache_assoc_way
    import cpu_types_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS_DEFAULT,
    parameter int WPB   = ICACHE_WPB_DEFAULT,
    parameter int IDX_W = 3,
    parameter int SEL_W = 1,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    input  logic [SEL_W-1:0] word_sel,
    input  logic             write_en,
    input  logic [31:0]      fill_word,
    input  logic             set_valid,
    input  logic             clear_valid,
    output logic             hit,
    output logic             valid,
    output logic [31:0]      data
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][WPB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[index] <= 1'b1;
        end else if (clear_valid) begin
            valid_q[index] <= 1'b0;
        end
    end

    // Tag and data carry no reset; the valid bit guards every read.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_q[index] <= tag;
        end
        if (write_en) begin
            data_q[index][word_sel] <= fill_word;
        end
    end

    assign valid = valid_q[index];
    assign hit   = valid_q[index] && (tag_q[index] == tag);
    assign data  = data_q[index][word_sel];

endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative multi-word instruction cache with LRU and hit/miss counters
module icache_assoc
    import cpu_types_pkg::*;
#(
    parameter int SETS            = ICACHE_SETS_DEFAULT,
    parameter int WAYS            = ICACHE_WAYS_DEFAULT,
    parameter int WORDS_PER_BLOCK = ICACHE_WPB_DEFAULT,
    parameter int CNT_W           = ICACHE_CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             nRST,
    datapath_cache_if.cache  dcif,
    caches_if.icache         cif,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int OFF_W = field_w(WORDS_PER_BLOCK);
    localparam int SEL_W = sel_w(WORDS_PER_BLOCK);
    localparam int IDX_W = field_w(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = sel_w(WAYS);
    localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(WORDS_PER_BLOCK - 1);

    icache_assoc_state_t state, state_n;

    logic [TAG_W-1:0] addr_tag, miss_tag, way_tag;
    logic [IDX_W-1:0] addr_idx, miss_idx, way_idx;
    logic [SEL_W-1:0] addr_word, fill_cnt, way_word;
    logic [WAY_W-1:0] victim, victim_n, hit_way;
    logic [WAYS-1:0]  way_hit, way_valid;
    logic [31:0]      way_data [WAYS];
    logic             req, in_fill, any_hit, hit_now, miss_start, word_accept, fill_last;

    assign addr_tag  = dcif.imemaddr[31 -: TAG_W];
    assign addr_idx  = dcif.imemaddr[2 + OFF_W +: IDX_W];
    assign addr_word = (OFF_W > 0) ? dcif.imemaddr[2 +: SEL_W] : '0;

    assign req         = dcif.imemREN && !dcif.dmemREN && !dcif.dmemWEN && !dcif.halt;
    assign in_fill     = (state == FILL);
    assign any_hit     = |way_hit;
    assign hit_now     = !in_fill && req && any_hit;
    assign miss_start  = !in_fill && req && !any_hit;
    assign word_accept = in_fill && !cif.iwait;
    assign fill_last   = word_accept && (fill_cnt == LAST_WORD);

    // During a fill the ways are addressed by the latched miss, not the live fetch address.
    assign way_tag  = in_fill ? miss_tag : addr_tag;
    assign way_idx  = in_fill ? miss_idx : addr_idx;
    assign way_word = in_fill ? fill_cnt : addr_word;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_assoc_way #(
            .SETS(SETS), .WPB(WORDS_PER_BLOCK), .IDX_W(IDX_W), .SEL_W(SEL_W), .TAG_W(TAG_W)
        ) u_way (
            .clk        (CLK),
            .rst_n      (nRST),
            .index      (way_idx),
            .tag        (way_tag),
            .word_sel   (way_word),
            .write_en   (word_accept && (victim == WAY_W'(w))),
            .fill_word  (cif.iload),
            .set_valid  (fill_last && (victim == WAY_W'(w))),
            .clear_valid(miss_start && (victim_n == WAY_W'(w))),
            .hit        (way_hit[w]),
            .valid      (way_valid[w]),
            .data       (way_data[w])
        );
    end

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_way = WAY_W'(w);
        end
    end

    if (WAYS == 2) begin : g_lru
        // lru[set] names the least-recently-used way of that set.
        logic [SETS-1:0] lru;

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                lru <= '0;
            end else if (hit_now) begin
                lru[addr_idx] <= ~hit_way;
            end else if (fill_last) begin
                lru[miss_idx] <= ~victim;
            end
        end

        assign victim_n = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[addr_idx]);
    end else begin : g_direct
        assign victim_n = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        cif.iREN      = 1'b0;
        cif.iaddr     = '0;
        dcif.ihit     = 1'b0;
        dcif.imemload = '0;
        case (state)
            IDLE: begin
                if (hit_now) begin
                    dcif.ihit     = 1'b1;
                    dcif.imemload = way_data[hit_way];
                end
                if (miss_start) state_n = FILL;
            end
            FILL: begin
                cif.iREN  = 1'b1;
                cif.iaddr = (32'({miss_tag, miss_idx}) << (2 + OFF_W)) | (32'(fill_cnt) << 2);
                if (fill_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_tag <= '0;
            miss_idx <= '0;
            victim   <= '0;
            fill_cnt <= '0;
        end else if (miss_start) begin
            miss_tag <= addr_tag;
            miss_idx <= addr_idx;
            victim   <= victim_n;
            fill_cnt <= '0;
        end else if (word_accept) begin
            fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_now && (hit_count != '1)) hit_count <= hit_count + 1'b1;
            if (miss_start && (miss_count != '1)) miss_count <= miss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - directed self-checking bench for icache_assoc
module tb_icache_assoc;

    logic        CLK;
    logic        nRST;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    datapath_cache_if dif ();
    caches_if         mif ();

    icache_assoc #(
        .SETS(8), .WAYS(2), .WORDS_PER_BLOCK(2), .CNT_W(32)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .dcif      (dif),
        .cif       (mif),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;
    int eh     = 0;
    int em     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [31:0] addr);
        dif.imemaddr = addr;
        dif.imemREN  = 1'b1;
    endtask

    task automatic check_counts(input string tag);
        @(negedge CLK);
        chk({tag, "_hits"}, hit_count, 32'(eh));
        chk({tag, "_misses"}, miss_count, 32'(em));
        next_cycle();
    endtask

    task automatic serve_word(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input int waits);
        for (int i = 0; i < waits; i++) begin
            mif.iwait = 1'b1;
            @(negedge CLK);
            chk({tag, "_wait_iren"}, 32'(mif.iREN), 32'd1);
            chk({tag, "_wait_iaddr"}, mif.iaddr, addr);
            chk({tag, "_wait_ihit"}, 32'(dif.ihit), 32'd0);
            next_cycle();
        end
        mif.iwait = 1'b0;
        mif.iload = data;
        @(negedge CLK);
        chk({tag, "_iren"}, 32'(mif.iREN), 32'd1);
        chk({tag, "_iaddr"}, mif.iaddr, addr);
        chk({tag, "_ihit"}, 32'(dif.ihit), 32'd0);
        next_cycle();
        mif.iwait = 1'b1;
    endtask

    // Miss, fill both words, then take the re-presented hit on word 0.
    task automatic miss_fill(input string tag, input logic [31:0] addr, input logic [31:0] d0,
                             input logic [31:0] d1, input int waits);
        present(addr);
        @(negedge CLK);
        chk({tag, "_miss_ihit"}, 32'(dif.ihit), 32'd0);
        chk({tag, "_miss_iren"}, 32'(mif.iREN), 32'd0);
        next_cycle();
        em++;
        serve_word({tag, "_w0"}, addr, d0, waits);
        serve_word({tag, "_w1"}, addr + 32'd4, d1, waits);
        @(negedge CLK);
        chk({tag, "_after_ihit"}, 32'(dif.ihit), 32'd1);
        chk({tag, "_after_load"}, dif.imemload, d0);
        next_cycle();
        eh++;
        dif.imemREN = 1'b0;
    endtask

    task automatic hit(input string tag, input logic [31:0] addr, input logic [31:0] d);
        present(addr);
        @(negedge CLK);
        chk({tag, "_ihit"}, 32'(dif.ihit), 32'd1);
        chk({tag, "_load"}, dif.imemload, d);
        next_cycle();
        eh++;
        dif.imemREN = 1'b0;
    endtask

    task automatic gated(input string tag);
        present(32'h40);
        @(negedge CLK);
        chk({tag, "_ihit"}, 32'(dif.ihit), 32'd0);
        chk({tag, "_load"}, dif.imemload, 32'd0);
        chk({tag, "_iren"}, 32'(mif.iREN), 32'd0);
        next_cycle();
        dif.imemREN = 1'b0;
        dif.dmemREN = 1'b0;
        dif.dmemWEN = 1'b0;
        dif.halt    = 1'b0;
        check_counts(tag);
    endtask

    initial begin
        nRST         = 1'b0;
        dif.halt     = 1'b0;
        dif.imemREN  = 1'b0;
        dif.imemaddr = '0;
        dif.dmemREN  = 1'b0;
        dif.dmemWEN  = 1'b0;
        mif.iwait    = 1'b1;
        mif.iload    = '0;

        @(negedge CLK);
        chk("rst_iren", 32'(mif.iREN), 32'd0);
        chk("rst_iaddr", mif.iaddr, 32'd0);
        chk("rst_ihit", 32'(dif.ihit), 32'd0);
        chk("rst_load", dif.imemload, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        next_cycle();
        nRST = 1'b1;
        next_cycle();

        // Cold miss and fill
        miss_fill("cold", 32'h40, 32'hAAAA0001, 32'hAAAA0002, 0);
        hit("cold_w1", 32'h44, 32'hAAAA0002);
        check_counts("cold");

        // Associativity and LRU in set 0
        miss_fill("way1", 32'h240, 32'hBBBB0001, 32'hBBBB0002, 0);
        hit("touch40", 32'h40, 32'hAAAA0001);
        miss_fill("evict240", 32'h440, 32'hCCCC0001, 32'hCCCC0002, 0);
        hit("keep40", 32'h40, 32'hAAAA0001);
        present(32'h240);
        @(negedge CLK);
        chk("gone240_ihit", 32'(dif.ihit), 32'd0);
        next_cycle();
        em++;
        chk("gone240_misses", miss_count, 32'd4);
        serve_word("refill240_w0", 32'h240, 32'hBBBB0001, 0);
        serve_word("refill240_w1", 32'h244, 32'hBBBB0002, 0);
        hit("refill240", 32'h244, 32'hBBBB0002);
        check_counts("lru");

        // Gating
        dif.dmemREN = 1'b1;
        gated("gate_dren");
        dif.dmemWEN = 1'b1;
        gated("gate_dwen");
        dif.halt = 1'b1;
        gated("gate_halt");

        // Wait states: LRU way 0 (0x40) is the victim
        miss_fill("waits80", 32'h80, 32'hEEEE0001, 32'hEEEE0002, 3);
        check_counts("waits");

        // Move 0x80 back out of set 0
        miss_fill("refill440", 32'h440, 32'hCCCC0001, 32'hCCCC0002, 0);
        miss_fill("refill40", 32'h40, 32'hAAAA0001, 32'hAAAA0002, 0);
        hit("gone80_check40", 32'h40, 32'hAAAA0001);

        // Address change mid-fill
        present(32'h80);
        @(negedge CLK);
        chk("chg_miss_ihit", 32'(dif.ihit), 32'd0);
        next_cycle();
        em++;
        serve_word("chg_w0", 32'h80, 32'hFFFF0001, 0);
        dif.imemaddr = 32'h100;
        serve_word("chg_w1", 32'h84, 32'hFFFF0002, 0);
        @(negedge CLK);
        chk("chg_new_ihit", 32'(dif.ihit), 32'd0);
        chk("chg_new_iren", 32'(mif.iREN), 32'd0);
        next_cycle();
        em++;
        chk("chg_new_misses", miss_count, 32'(em));
        serve_word("chg100_w0", 32'h100, 32'h11110001, 0);
        serve_word("chg100_w1", 32'h104, 32'h11110002, 0);
        @(negedge CLK);
        chk("chg100_ihit", 32'(dif.ihit), 32'd1);
        chk("chg100_load", dif.imemload, 32'h11110001);
        next_cycle();
        eh++;
        hit("chg80_later", 32'h84, 32'hFFFF0002);
        check_counts("chg");

        // Reset mid-fill
        miss_fill("pre_rst40", 32'h40, 32'hAAAA0001, 32'hAAAA0002, 0);
        present(32'h180);
        next_cycle();
        #1;
        chk("midfill_iren", 32'(mif.iREN), 32'd1);
        chk("midfill_iaddr", mif.iaddr, 32'h180);
        nRST = 1'b0;
        #1;
        chk("arst_iren", 32'(mif.iREN), 32'd0);
        chk("arst_iaddr", mif.iaddr, 32'd0);
        chk("arst_hits", hit_count, 32'd0);
        chk("arst_misses", miss_count, 32'd0);
        eh = 0;
        em = 0;
        next_cycle();
        nRST = 1'b1;
        present(32'h40);
        @(negedge CLK);
        chk("post_rst40_ihit", 32'(dif.ihit), 32'd0);
        next_cycle();
        em++;
        @(negedge CLK);
        chk("post_rst40_iren", 32'(mif.iREN), 32'd1);
        chk("post_rst40_iaddr", mif.iaddr, 32'h40);
        chk("post_rst40_misses", miss_count, 32'(em));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
